// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller:
// access sizes, FSM states and the alignment rule.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // An access is legal when the size is defined and the address is
    // naturally aligned for that size.
    function automatic logic access_legal(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extender.sv
// Selects the addressed byte/half lane of a returned word and zero- or
// sign-extends it to 32 bits. Purely combinational.
module load_extender
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [7:0]  byte_cand [4];
    logic [15:0] half_cand [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_cand[gi] = word[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_cand[gi] = word[16*gi +: 16];
        end
    endgenerate

    assign byte_lane = byte_cand[addr_lo];
    assign half_lane = half_cand[addr_lo[1]];

    always_comb begin
        ext = 32'd0;
        case (size)
            SIZE_BYTE: ext = {{24{~zext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: ext = {{16{~zext & half_lane[15]}}, half_lane};
            SIZE_WORD: ext = word;
            default:   ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: drives one req/ack bus transaction per
// legal access, stalls the pipeline meanwhile and returns extended load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_zext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [1:0]  addr_lo_reg;
    logic [1:0]  size_reg;
    logic        zext_reg;

    logic        done_reg;
    logic        misalign_reg;
    logic        bus_err_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] rdata_reg;

    logic        req_legal;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] ext_data;

    assign req_legal = access_legal(req_size, req_addr[1:0]);

    always_comb begin
        be_next = 4'b0000;
        case (req_size)
            SIZE_BYTE: be_next = 4'b0001 << req_addr[1:0];
            SIZE_HALF: be_next = req_addr[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be_next = 4'b1111;
            default:   be_next = 4'b0000;
        endcase
    end

    // Replicate the right-justified store data into every lane it may land in.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            always_comb begin
                wdata_next[8*gi +: 8] = 8'd0;
                if (req_we) begin
                    case (req_size)
                        SIZE_BYTE: wdata_next[8*gi +: 8] = req_wdata[7:0];
                        SIZE_HALF: wdata_next[8*gi +: 8] = req_wdata[8*(gi%2) +: 8];
                        default:   wdata_next[8*gi +: 8] = req_wdata[8*gi +: 8];
                    endcase
                end
            end
        end
    endgenerate

    load_extender u_load_extender (
        .word    (mem_rdata),
        .addr_lo (addr_lo_reg),
        .size    (size_reg),
        .zext    (zext_reg),
        .ext     (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 8'd0;
            addr_lo_reg   <= 2'b00;
            size_reg      <= SIZE_BYTE;
            zext_reg      <= 1'b0;
            done_reg      <= 1'b0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= 32'd0;
            rdata_reg     <= 32'd0;
        end else begin
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_legal) begin
                            state_reg     <= ST_REQ;
                            wait_cnt_reg  <= 8'd0;
                            addr_lo_reg   <= req_addr[1:0];
                            size_reg      <= req_size;
                            zext_reg      <= req_zext;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= req_we;
                            mem_addr_reg  <= {req_addr[31:2], 2'b00};
                            mem_be_reg    <= be_next;
                            mem_wdata_reg <= wdata_next;
                        end else begin
                            misalign_reg <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        rdata_reg   <= ext_data;
                        done_reg    <= 1'b1;
                        mem_req_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        rdata_reg   <= 32'd0;
                        done_reg    <= 1'b1;
                        bus_err_reg <= 1'b1;
                        mem_req_reg <= 1'b0;
                        state_reg   <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the pipeline freezes in the very cycle it is accepted.
    assign stall = ((state_reg == ST_IDLE) & req_valid & req_legal) | (state_reg == ST_REQ);

    assign done      = done_reg;
    assign rdata     = rdata_reg;
    assign misalign  = misalign_reg;
    assign bus_err   = bus_err_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected completions are queued when a
// request is driven and compared when done pulses.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_zext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misalign, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        bus_err;
        int          latency;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_zext(req_zext), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] sz, input logic zx);
        logic [31:0] v;
        v = w;
        if (sz == 2'b00) begin
            v = (w >> (a[1:0] * 8)) & 32'h0000_00FF;
            if (!zx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (!zx && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b00) return 4'b0001 << a[1:0];
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // ack_delay < 0 means the bus never acknowledges.
    task automatic do_access(input string name, input logic we, input logic [1:0] size,
                             input logic zext, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rword, input int ack_delay);
        exp_t e, got;
        int cyc, reqc;
        bit seen_done;
        e.bus_err   = (ack_delay < 0);
        e.chk_rdata = e.bus_err || !we;
        e.rdata     = e.bus_err ? 32'd0 : model_load(rword, addr, size, zext);
        e.latency   = e.bus_err ? int'(TIMEOUT) + 1 : ack_delay + 2;
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_size = size; req_zext = zext;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        checks++; if (stall !== 1'b1) $display("FAIL %s_accept_stall: got %b want 1", name, stall); else passes++;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_zext = ~zext;
        cyc = 0; reqc = 0; seen_done = 0;
        while (!seen_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack = 0; mem_rdata = ~rword;
            if (mem_req) begin
                if (reqc == 0) begin
                    checks++; if (mem_addr !== {addr[31:2], 2'b00}) $display("FAIL %s_addr: got %h want %h", name, mem_addr, {addr[31:2], 2'b00}); else passes++;
                    checks++; if (mem_be !== model_be(addr, size)) $display("FAIL %s_be: got %b want %b", name, mem_be, model_be(addr, size)); else passes++;
                    checks++; if (mem_we !== we) $display("FAIL %s_we: got %b want %b", name, mem_we, we); else passes++;
                    checks++; if (mem_wdata !== (we ? model_wdata(wdata, size) : 32'd0)) $display("FAIL %s_wdata: got %h want %h", name, mem_wdata, we ? model_wdata(wdata, size) : 32'd0); else passes++;
                    checks++; if (stall !== 1'b1) $display("FAIL %s_req_stall: got %b want 1", name, stall); else passes++;
                end
                if (reqc == ack_delay) begin mem_ack = 1; mem_rdata = rword; end
                reqc++;
            end
            if (done) begin
                seen_done = 1;
                got = sb_q.pop_front();
                checks++; if (cyc !== got.latency) $display("FAIL %s_latency: got %0d want %0d", name, cyc, got.latency); else passes++;
                checks++; if (bus_err !== got.bus_err) $display("FAIL %s_bus_err: got %b want %b", name, bus_err, got.bus_err); else passes++;
                if (got.chk_rdata) begin
                    checks++; if (rdata !== got.rdata) $display("FAIL %s_rdata: got %h want %h", name, rdata, got.rdata); else passes++;
                end
                checks++; if ({stall, mem_req} !== 2'b00) $display("FAIL %s_done_idle: got stall/mem_req %b want 00", name, {stall, mem_req}); else passes++;
                if (got.bus_err) begin
                    checks++; if (reqc !== int'(TIMEOUT)) $display("FAIL %s_req_cycles: got %0d want %0d", name, reqc, TIMEOUT); else passes++;
                end
            end
        end
        mem_ack = 0;
        checks++; if (!seen_done) $display("FAIL %s_no_done: got none within %0d cycles want done", name, cyc); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL %s_done_width: got %b want 0", name, done); else passes++;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_zext = 0;
        req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({stall, done, misalign, bus_err, mem_req, mem_we} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {stall, done, misalign, bus_err, mem_req, mem_we}); else passes++;
        checks++; if ({mem_addr, mem_be, mem_wdata, rdata} !== 100'd0) $display("FAIL reset_data: got %h %b %h %h want zeros", mem_addr, mem_be, mem_wdata, rdata); else passes++;
        rst_n = 1;
    endtask

    task automatic test_load_byte();
        do_access("ldb", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8011_2233, 0);
    endtask

    task automatic test_load_half();
        do_access("ldhu", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h9ABC_1234, 1);
        do_access("ldhs", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h9ABC_1234, 0);
    endtask

    task automatic test_store_byte();
        do_access("stb", 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00A5, 32'h0, 2);
    endtask

    task automatic test_misalign(input string name, input logic [1:0] size, input logic [31:0] addr);
        int reqs;
        reqs = 0;
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_size = size; req_addr = addr;
        @(negedge clk);
        checks++; if ({stall, mem_req} !== 2'b00) $display("FAIL %s_stall: got stall/mem_req %b want 00", name, {stall, mem_req}); else passes++;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        checks++; if ({misalign, done} !== 2'b10) $display("FAIL %s_pulse: got misalign/done %b want 10", name, {misalign, done}); else passes++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req || misalign) reqs++;
        end
        checks++; if (reqs !== 0) $display("FAIL %s_after: got %0d cycles with mem_req/misalign want 0", name, reqs); else passes++;
    endtask

    task automatic test_timeout();
        int bad;
        do_access("tmo", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1234_5678, -1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            if (done || mem_req || bus_err) bad++;
        end
        mem_ack = 0;
        checks++; if (bad !== 0) $display("FAIL tmo_late_ack: got %0d reacting cycles want 0", bad); else passes++;
        checks++; if (rdata !== 32'd0) $display("FAIL tmo_rdata_hold: got %h want 00000000", rdata); else passes++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_size = 2'b10; req_zext = 0; req_addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) $display("FAIL rstmid_inreq: got mem_req %b want 1", mem_req); else passes++;
        #2 rst_n = 0;
        #1;
        checks++; if ({mem_req, stall} !== 2'b00) $display("FAIL rstmid_async: got mem_req/stall %b want 00", {mem_req, stall}); else passes++;
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if ({done, mem_req, bus_err} !== 3'b000) $display("FAIL rstmid_late_ack: got done/mem_req/bus_err %b want 000", {done, mem_req, bus_err}); else passes++;
        checks++; if (rdata !== 32'd0) $display("FAIL rstmid_rdata: got %h want 00000000", rdata); else passes++;
        mem_ack = 0;
        do_access("rstmid_fresh", 1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 32'h00F1_0000, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a, d, w;
        logic        we, zx;
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom; d = $urandom; w = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            we = 1'($urandom_range(0, 1));
            zx = 1'($urandom_range(0, 1));
            do_access("b2b", we, sz, zx, a, d, w, int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_byte();
        test_misalign("mis_word", 2'b10, 32'h102);
        test_misalign("mis_size", 2'b11, 32'h100);
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++; if (sb_q.size() !== 0) $display("FAIL sb_empty: got %0d pending want 0", sb_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
